// File: rtl/dmem_wait_responder.sv
// Word-addressed data-memory responder: accepts one access at a time, holds it
// for LATENCY wait cycles, then completes with a one-cycle done pulse.
module dmem_wait_responder #(
  parameter int AW_WORDS = 6,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         DEPTH    = 1 << AW_WORDS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         ram_rd_q;
  logic [AW_WORDS-1:0] acc_idx;
  logic [AW_WORDS-1:0] rd_idx;
  logic                access;
  logic                acc_valid;
  logic                mem_we;

  assign acc_idx   = addr_q[AW_WORDS+1:2];
  assign acc_valid = (addr_q[1:0] == 2'b00) && ((addr_q >> (AW_WORDS + 2)) == 32'd0);
  assign access    = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we    = access && acc_valid && we_q;

  // The array is read one edge ahead of the access: from the live address on
  // the accepting edge, then from the captured address while waiting. Only
  // the in-flight request can write, so the prefetched word is never stale.
  assign rd_idx = (state_q == IDLE) ? addr[AW_WORDS+1:2] : acc_idx;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= wdata_q;
    end
    ram_rd_q <= mem[rd_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (!acc_valid) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else begin
            err_d = 1'b0;
            if (!we_q) begin
              rdata_d = ram_rd_q;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset while waiting drops the captured request, so a pending write never commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Randomized bench for dmem_wait_responder: a transaction-level model predicts
// accept/complete timing and memory contents; one process compares every cycle.
module tb_dmem_wait_responder;

  parameter int AW_WORDS = 6;
  parameter int LATENCY  = 2;
  localparam int DEPTH = 1 << AW_WORDS;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  dmem_wait_responder #(
    .AW_WORDS(AW_WORDS),
    .LATENCY (LATENCY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .ready(ready),
    .done (done),
    .rdata(rdata),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Stimulus-side bookkeeping
  int          cur_tag = -1;
  bit          stim_timeout = 1'b0;
  bit          stim_done = 1'b0;
  int          lit_cnt = 0;
  bit          lit_has_rd [64];
  logic [31:0] lit_rd [64];
  bit          lit_err [64];

  // Model state
  int          edge_k = 0;
  int          free_edge = 0;
  int          done_edge = 0;
  bit          pend = 1'b0;
  bit          p_we;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  int          p_tag;
  logic [31:0] mem_m [DEPTH];
  bit          exp_ready = 1'b1;
  bit          exp_done = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  bit          exp_err = 1'b0;
  int          exp_tag = -1;

  // Compare-side counters
  int vectors = 0;
  int miscompares = 0;
  int lit_seen = 0;

  // Transaction model: an accepted request completes LATENCY edges later and
  // the responder is free again two edges after that.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        pend      = 1'b0;
        free_edge = 0;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        exp_tag   = -1;
      end else begin
        edge_k++;
        exp_done = 1'b0;
        if (pend && edge_k == done_edge) begin
          pend     = 1'b0;
          exp_done = 1'b1;
          exp_tag  = p_tag;
          if (p_addr % 4 == 0 && (p_addr / 4) < DEPTH) begin
            exp_err = 1'b0;
            if (p_we) mem_m[p_addr / 4] = p_wdata;
            else      exp_rdata = mem_m[p_addr / 4];
          end else begin
            exp_err   = 1'b1;
            exp_rdata = 32'd0;
          end
        end else if (edge_k >= free_edge && req === 1'b1) begin
          pend      = 1'b1;
          p_we      = we;
          p_addr    = addr;
          p_wdata   = wdata;
          p_tag     = cur_tag;
          done_edge = edge_k + LATENCY;
          free_edge = edge_k + LATENCY + 2;
        end
        exp_ready = (edge_k + 1 >= free_edge);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (stim_done) begin
        chk("stim_timeout", 32'(stim_timeout), 32'd0);
        chk("directed_completions", 32'(lit_seen), 32'(lit_cnt));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("done", 32'(done), 32'(exp_done));
      if (!reset) begin
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
      end else if (exp_done) begin
        chk("rdata", rdata, exp_rdata);
        chk("err", 32'(err), 32'(exp_err));
        if (exp_tag >= 0) begin
          lit_seen++;
          if (lit_has_rd[exp_tag]) chk("lit_rdata", rdata, lit_rd[exp_tag]);
          chk("lit_err", 32'(err), 32'(lit_err[exp_tag]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  function automatic int lit(input bit has_rd, input logic [31:0] rd, input bit e);
    lit_has_rd[lit_cnt] = has_rd;
    lit_rd[lit_cnt]     = rd;
    lit_err[lit_cnt]    = e;
    lit_cnt++;
    return lit_cnt - 1;
  endfunction

  // Drive a request and return 2 time units after the edge that accepts it.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, input int t);
    bit r;
    we      = w;
    addr    = a;
    wdata   = d;
    cur_tag = t;
    req     = 1'b1;
    for (int n = 0; n < 200; n++) begin
      r = ready;
      @(posedge clk);
      #2;
      if (r) return;
    end
    stim_timeout = 1'b1;
  endtask

  task automatic idle();
    req     = 1'b0;
    cur_tag = -1;
    @(posedge clk);
    #2;
  endtask

  task automatic garbage();
    req     = 1'($urandom);
    we      = 1'($urandom);
    addr    = $urandom;
    wdata   = $urandom;
    cur_tag = -1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    reset = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    idle();

    // Write then read
    do_req(1'b1, 32'd84, 32'd7, lit(1'b0, 32'd0, 1'b0));
    idle();
    do_req(1'b0, 32'd84, 32'd0, lit(1'b1, 32'd7, 1'b0));
    idle();

    // Back-to-back with req held high
    do_req(1'b1, 32'd80, 32'd5, lit(1'b0, 32'd0, 1'b0));
    do_req(1'b1, 32'd84, 32'd7, lit(1'b0, 32'd0, 1'b0));
    do_req(1'b0, 32'd80, 32'd0, lit(1'b1, 32'd5, 1'b0));
    idle();

    // Error accesses leave word 0 untouched
    do_req(1'b1, 32'd0, 32'hA5A5_A5A5, lit(1'b0, 32'd0, 1'b0));
    idle();
    do_req(1'b0, 32'd86, 32'd0, lit(1'b1, 32'd0, 1'b1));
    do_req(1'b1, 32'd256, 32'h0000_1234, lit(1'b1, 32'd0, 1'b1));
    do_req(1'b0, 32'd0, 32'd0, lit(1'b1, 32'hA5A5_A5A5, 1'b0));
    idle();

    // Reset before a pending write commits
    do_req(1'b1, 32'd8, 32'h1111_1111, lit(1'b0, 32'd0, 1'b0));
    idle();
    do_req(1'b1, 32'd8, 32'hDEAD_BEEF, -1);
    req   = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    idle();
    do_req(1'b0, 32'd8, 32'd0, lit(1'b1, 32'h1111_1111, 1'b0));
    idle();

    // Fill every word so random reads have defined data
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b1, 32'(i * 4), $urandom, -1);
    end
    idle();

    // Random traffic with req/inputs toggling while the responder is busy
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (kind == 1) a = ($urandom | 32'h0000_0100) & ~32'h3;
      else if (kind == 2) a = ($urandom_range(0, 1) == 1) ? 32'(DEPTH * 4) : 32'(DEPTH * 4 - 4);
      else                a = 32'($urandom_range(0, DEPTH - 1) * 4);
      do_req(1'($urandom), a, $urandom, -1);
      for (int g = int'($urandom_range(0, LATENCY - 1)); g > 0; g--) garbage();
      if ($urandom_range(0, 3) == 0) idle();
    end

    repeat (LATENCY + 3) idle();
    stim_done = 1'b1;
  end

endmodule
